// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard/control bundle between the datapath and the pipeline sequencer.
// The datapath (master) reports cache strobes and hazards; the sequencer (slave) drives enables/flushes.
interface pipeline_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   ihit;
    logic                   dhit;
    logic                   dREN_EX_MEM;
    logic                   dWEN_EX_MEM;
    logic                   halt_EX_MEM;
    logic                   branch_taken_EX_MEM;
    logic                   jump_IF_ID;
    logic                   dREN_ID_EX;
    logic                   WEN_ID_EX;
    logic [4:0]             Rt_ID_EX;
    logic [4:0]             Rs_IF_ID;
    logic [4:0]             Rt_IF_ID;

    logic                   pc_enable;
    logic                   enable_IF_ID;
    logic                   enable_ID_EX;
    logic                   enable_EX_MEM;
    logic                   enable_MEM_WB;
    logic                   flush_IF_ID;
    logic                   flush_ID_EX;
    logic                   flush_EX_MEM;
    logic                   dmem_req_ok;
    logic                   halt;
    logic [1:0]             ctrl_state;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM,
               branch_taken_EX_MEM, jump_IF_ID, dREN_ID_EX, WEN_ID_EX,
               Rt_ID_EX, Rs_IF_ID, Rt_IF_ID,
        input  pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, dmem_req_ok, halt,
               ctrl_state, stall_count
    );

    modport slave (
        input  ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM,
               branch_taken_EX_MEM, jump_IF_ID, dREN_ID_EX, WEN_ID_EX,
               Rt_ID_EX, Rs_IF_ID, Rt_IF_ID,
        output pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, dmem_req_ok, halt,
               ctrl_state, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: memory wait, fetch wait,
// load-use and control hazards, and the halt drain into a terminal halted state.
module pipeline_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input logic                    CLK,
    input logic                    RST,
    pipeline_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   halt_q, halt_d;
    logic                   req_blk_q, req_blk_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic mem_op_s, mem_ok_s, load_use_s;
    logic pc_en_s, en_if_id_s, en_id_ex_s, en_ex_mem_s, en_mem_wb_s;
    logic fl_if_id_s, fl_id_ex_s, fl_ex_mem_s;

    // Hazard detection terms.
    always_comb begin
        mem_op_s   = bus.dREN_EX_MEM | bus.dWEN_EX_MEM;
        mem_ok_s   = ~mem_op_s | bus.dhit;
        load_use_s = bus.dREN_ID_EX & bus.WEN_ID_EX & (bus.Rt_ID_EX != 5'd0) &
                     ((bus.Rt_ID_EX == bus.Rs_IF_ID) | (bus.Rt_ID_EX == bus.Rt_IF_ID));
    end

    // Enable/flush decode and next-state logic; reset forces every enable low.
    always_comb begin
        pc_en_s     = 1'b0;
        en_if_id_s  = 1'b0;
        en_id_ex_s  = 1'b0;
        en_ex_mem_s = 1'b0;
        en_mem_wb_s = 1'b0;
        fl_if_id_s  = 1'b0;
        fl_id_ex_s  = 1'b0;
        fl_ex_mem_s = 1'b0;
        state_d     = state_q;
        halt_d      = halt_q;
        if (RST) begin
            state_d = ST_RUN;
            halt_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    if (bus.halt_EX_MEM && mem_ok_s) begin
                        {en_if_id_s, en_id_ex_s, en_ex_mem_s, en_mem_wb_s} = 4'b1111;
                        {fl_if_id_s, fl_id_ex_s, fl_ex_mem_s}              = 3'b111;
                        state_d = ST_DRAIN;
                    end else if (!mem_ok_s) begin
                        state_d = ST_MEM_WAIT;
                    end else if (mem_op_s && bus.dhit && !bus.ihit) begin
                        // Retire the completed access and bubble EX_MEM so dhit is not lost.
                        en_ex_mem_s = 1'b1;
                        en_mem_wb_s = 1'b1;
                        fl_ex_mem_s = 1'b1;
                        state_d     = ST_RUN;
                    end else if (!bus.ihit) begin
                        state_d = ST_RUN;
                    end else if (bus.branch_taken_EX_MEM) begin
                        {pc_en_s, en_if_id_s, en_id_ex_s, en_ex_mem_s, en_mem_wb_s} = 5'b11111;
                        {fl_if_id_s, fl_id_ex_s, fl_ex_mem_s}                       = 3'b111;
                        state_d = ST_RUN;
                    end else if (load_use_s) begin
                        {en_id_ex_s, en_ex_mem_s, en_mem_wb_s} = 3'b111;
                        fl_id_ex_s = 1'b1;
                        state_d    = ST_RUN;
                    end else if (bus.jump_IF_ID) begin
                        {pc_en_s, en_if_id_s, en_id_ex_s, en_ex_mem_s, en_mem_wb_s} = 5'b11111;
                        fl_if_id_s = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        {pc_en_s, en_if_id_s, en_id_ex_s, en_ex_mem_s, en_mem_wb_s} = 5'b11111;
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    en_mem_wb_s = 1'b1;
                    halt_d      = 1'b1;
                    state_d     = ST_HALTED;
                end
                ST_HALTED: begin
                    halt_d  = 1'b1;
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Re-request mask and saturating stall counter next values.
    always_comb begin
        req_blk_d = ~en_ex_mem_s & (bus.dhit | req_blk_q);
        if (!pc_en_s && (state_q != ST_HALTED) && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // Sequencer state, sticky halt, request mask and stall counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_RUN;
            halt_q    <= 1'b0;
            req_blk_q <= 1'b0;
            stall_q   <= {STALL_CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            halt_q    <= halt_d;
            req_blk_q <= req_blk_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.pc_enable     = pc_en_s;
    assign bus.enable_IF_ID  = en_if_id_s;
    assign bus.enable_ID_EX  = en_id_ex_s;
    assign bus.enable_EX_MEM = en_ex_mem_s;
    assign bus.enable_MEM_WB = en_mem_wb_s;
    assign bus.flush_IF_ID   = fl_if_id_s;
    assign bus.flush_ID_EX   = fl_id_ex_s;
    assign bus.flush_EX_MEM  = fl_ex_mem_s;
    assign bus.dmem_req_ok   = ~req_blk_q;
    assign bus.halt          = halt_q;
    assign bus.ctrl_state    = state_q;
    assign bus.stall_count   = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven scoreboard bench for pipeline_hazard_ctrl (narrow stall counter to reach saturation).
module tb_pipeline_hazard_ctrl;

    localparam int W = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl_if #(.STALL_CNT_W(W)) bus ();

    pipeline_hazard_ctrl #(.STALL_CNT_W(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // input bits: rst ihit dhit dREN_MEM dWEN_MEM halt_MEM br jmp dREN_EX WEN_EX
    localparam logic [9:0] I_NONE = 10'b00_0000_0000;
    localparam logic [9:0] I_RST  = 10'b10_0000_0000;
    localparam logic [9:0] I_IH   = 10'b01_0000_0000;
    localparam logic [9:0] I_DH   = 10'b00_1000_0000;
    localparam logic [9:0] I_DRM  = 10'b00_0100_0000;
    localparam logic [9:0] I_DWM  = 10'b00_0010_0000;
    localparam logic [9:0] I_HLT  = 10'b00_0001_0000;
    localparam logic [9:0] I_BR   = 10'b00_0000_1000;
    localparam logic [9:0] I_JMP  = 10'b00_0000_0100;
    localparam logic [9:0] I_LDX  = 10'b00_0000_0011;

    // outputs: pc eIF eID eEX eWB fIF fID fEX dmem_req_ok
    localparam logic [8:0] C_ALL     = 9'b1_1111_000_1;
    localparam logic [8:0] C_ALL_BLK = 9'b1_1111_000_0;
    localparam logic [8:0] C_ZERO    = 9'b0_0000_000_1;
    localparam logic [8:0] C_ZER_BLK = 9'b0_0000_000_0;
    localparam logic [8:0] C_DBUB    = 9'b0_0011_001_1;
    localparam logic [8:0] C_LU      = 9'b0_0111_010_1;
    localparam logic [8:0] C_BR      = 9'b1_1111_111_1;
    localparam logic [8:0] C_JMP     = 9'b1_1111_100_1;
    localparam logic [8:0] C_HLT     = 9'b0_1111_111_1;
    localparam logic [8:0] C_DRN     = 9'b0_0001_000_1;

    typedef struct {
        logic [9:0] in;
        logic [4:0] rt_ex, rs_id, rt_id;
        logic [8:0] exp_ctl;
        logic [1:0] exp_state;
        logic       exp_halt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec   = 0;
    int   n_fail  = 0;
    int   vec_id  = 0;
    logic [W-1:0] exp_stall = '0;

    function automatic vec_t mk(input logic [9:0] in, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                                input logic [4:0] rt_id, input logic [8:0] ctl, input logic [1:0] st,
                                input logic hl);
        vec_t v;
        v.in = in; v.rt_ex = rt_ex; v.rs_id = rs_id; v.rt_id = rt_id;
        v.exp_ctl = ctl; v.exp_state = st; v.exp_halt = hl;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(posedge CLK);
        #1;
        RST                     = v.in[9];
        bus.ihit                = v.in[8];
        bus.dhit                = v.in[7];
        bus.dREN_EX_MEM         = v.in[6];
        bus.dWEN_EX_MEM         = v.in[5];
        bus.halt_EX_MEM         = v.in[4];
        bus.branch_taken_EX_MEM = v.in[3];
        bus.jump_IF_ID          = v.in[2];
        bus.dREN_ID_EX          = v.in[1];
        bus.WEN_ID_EX           = v.in[0];
        bus.Rt_ID_EX            = v.rt_ex;
        bus.Rs_IF_ID            = v.rs_id;
        bus.Rt_IF_ID            = v.rt_id;
        sb.push_back(v);
    endtask

    // Scoreboard: pop the expectation for this cycle and compare away from the active edge.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            vec_t v;
            logic [8:0]   act_ctl;
            logic [W-1:0] want_stall;
            v = sb.pop_front();
            act_ctl = {bus.pc_enable, bus.enable_IF_ID, bus.enable_ID_EX, bus.enable_EX_MEM,
                       bus.enable_MEM_WB, bus.flush_IF_ID, bus.flush_ID_EX, bus.flush_EX_MEM,
                       bus.dmem_req_ok};
            want_stall = v.in[9] ? '0 : exp_stall;
            n_vec++;
            if (act_ctl !== v.exp_ctl) begin
                n_fail++;
                $display("FAIL vec%0d ctl: got %b expected %b", vec_id, act_ctl, v.exp_ctl);
            end
            if (bus.ctrl_state !== v.exp_state) begin
                n_fail++;
                $display("FAIL vec%0d state: got %0d expected %0d", vec_id, bus.ctrl_state, v.exp_state);
            end
            if (bus.halt !== v.exp_halt) begin
                n_fail++;
                $display("FAIL vec%0d halt: got %b expected %b", vec_id, bus.halt, v.exp_halt);
            end
            if (bus.stall_count !== want_stall) begin
                n_fail++;
                $display("FAIL vec%0d stall_count: got %0d expected %0d", vec_id, bus.stall_count, want_stall);
            end
            if (v.in[9])
                exp_stall = '0;
            else if (!v.exp_ctl[8] && v.exp_state != 2'd3 && exp_stall != {W{1'b1}})
                exp_stall = exp_stall + {{(W-1){1'b0}}, 1'b1};
            vec_id++;
        end
    end

    task automatic direct_check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        bus.ihit = 1'b0; bus.dhit = 1'b0; bus.dREN_EX_MEM = 1'b0; bus.dWEN_EX_MEM = 1'b0;
        bus.halt_EX_MEM = 1'b0; bus.branch_taken_EX_MEM = 1'b0; bus.jump_IF_ID = 1'b0;
        bus.dREN_ID_EX = 1'b0; bus.WEN_ID_EX = 1'b0;
        bus.Rt_ID_EX = 5'd0; bus.Rs_IF_ID = 5'd0; bus.Rt_IF_ID = 5'd0;

        tbl.push_back(mk(I_RST, 5'd0, 5'd0, 5'd0, C_ZERO, 2'd0, 1'b0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(I_IH, 5'd0, 5'd0, 5'd0, C_ALL, 2'd0, 1'b0));
        // Data miss for three cycles, then the hit releases everything.
        tbl.push_back(mk(I_IH | I_DRM, 5'd0, 5'd0, 5'd0, C_ZERO, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH | I_DRM, 5'd0, 5'd0, 5'd0, C_ZERO, 2'd1, 1'b0));
        tbl.push_back(mk(I_IH | I_DRM, 5'd0, 5'd0, 5'd0, C_ZERO, 2'd1, 1'b0));
        tbl.push_back(mk(I_IH | I_DRM | I_DH, 5'd0, 5'd0, 5'd0, C_ALL, 2'd1, 1'b0));
        tbl.push_back(mk(I_DH | I_DRM, 5'd0, 5'd0, 5'd0, C_DBUB, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH, 5'd0, 5'd0, 5'd0, C_ALL, 2'd0, 1'b0));
        // dhit while EX_MEM is frozen masks the next request until EX_MEM advances.
        tbl.push_back(mk(I_DH, 5'd0, 5'd0, 5'd0, C_ZERO, 2'd0, 1'b0));
        tbl.push_back(mk(I_NONE, 5'd0, 5'd0, 5'd0, C_ZER_BLK, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH, 5'd0, 5'd0, 5'd0, C_ALL_BLK, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH, 5'd0, 5'd0, 5'd0, C_ALL, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH | I_LDX, 5'd5, 5'd5, 5'd7, C_LU, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH | I_LDX, 5'd5, 5'd3, 5'd5, C_LU, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH | I_LDX, 5'd0, 5'd0, 5'd0, C_ALL, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH | 10'b00_0000_0010, 5'd5, 5'd5, 5'd0, C_ALL, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH | I_LDX | I_BR | I_JMP, 5'd5, 5'd5, 5'd0, C_BR, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH | I_JMP, 5'd0, 5'd0, 5'd0, C_JMP, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH | I_LDX | I_JMP, 5'd5, 5'd5, 5'd0, C_LU, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH | I_DH | I_DWM | I_BR, 5'd0, 5'd0, 5'd0, C_BR, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH | I_DWM | I_BR, 5'd0, 5'd0, 5'd0, C_ZERO, 2'd0, 1'b0));
        tbl.push_back(mk(I_DH | I_DWM, 5'd0, 5'd0, 5'd0, C_DBUB, 2'd1, 1'b0));
        tbl.push_back(mk(I_LDX, 5'd5, 5'd5, 5'd0, C_ZERO, 2'd0, 1'b0));
        // Long fetch wait drives the narrow counter into saturation.
        for (int i = 0; i < 20; i++) tbl.push_back(mk(I_NONE, 5'd0, 5'd0, 5'd0, C_ZERO, 2'd0, 1'b0));
        tbl.push_back(mk(I_IH, 5'd0, 5'd0, 5'd0, C_ALL, 2'd0, 1'b0));
        tbl.push_back(mk(I_RST, 5'd0, 5'd0, 5'd0, C_ZERO, 2'd0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Halt behind a data miss, drain, then a held halted state that ignores inputs.
        apply(mk(I_IH | I_HLT | I_DRM, 5'd0, 5'd0, 5'd0, C_ZERO, 2'd0, 1'b0));
        apply(mk(I_IH | I_HLT | I_DRM | I_DH | I_BR, 5'd0, 5'd0, 5'd0, C_HLT, 2'd1, 1'b0));
        apply(mk(I_IH | I_BR, 5'd0, 5'd0, 5'd0, C_DRN, 2'd2, 1'b0));
        for (int i = 0; i < 20; i++) apply(mk(I_IH | I_BR | I_JMP, 5'd0, 5'd0, 5'd0, C_ZERO, 2'd3, 1'b1));
        apply(mk(I_RST, 5'd0, 5'd0, 5'd0, C_ZERO, 2'd0, 1'b0));
        apply(mk(I_IH, 5'd0, 5'd0, 5'd0, C_ALL, 2'd0, 1'b0));

        // Asynchronous reset landing in the middle of the drain cycle.
        apply(mk(I_IH | I_HLT, 5'd0, 5'd0, 5'd0, C_HLT, 2'd0, 1'b0));
        @(posedge CLK);
        #1;
        bus.halt_EX_MEM = 1'b0;
        #2;
        direct_check("drain_state", {14'd0, bus.ctrl_state}, 16'd2);
        direct_check("drain_mem_wb", {15'd0, bus.enable_MEM_WB}, 16'd1);
        RST = 1'b1;
        #1;
        direct_check("async_rst_state", {14'd0, bus.ctrl_state}, 16'd0);
        direct_check("async_rst_stall", {12'd0, bus.stall_count}, 16'd0);
        direct_check("async_rst_halt", {15'd0, bus.halt}, 16'd0);
        direct_check("async_rst_mem_wb", {15'd0, bus.enable_MEM_WB}, 16'd0);
        direct_check("async_rst_dmem_ok", {15'd0, bus.dmem_req_ok}, 16'd1);
        apply(mk(I_RST, 5'd0, 5'd0, 5'd0, C_ZERO, 2'd0, 1'b0));
        apply(mk(I_IH, 5'd0, 5'd0, 5'd0, C_ALL, 2'd0, 1'b0));

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge CLK);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_scoreboard: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage MIPS pipeline. Generates the enable/flush pair for each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. Inputs are cache hit strobes, the load-use hazard, taken branches/jumps and halt. A small FSM handles the data-memory wait, the halt drain and the terminal halted state. The block sits beside the datapath and drives enable_*/flush_* on every register interface.

Parameters:
STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
CLK  in  1  pipeline clock
RST  in  1  asynchronous reset, active-high
ihit  in  1  instruction fetch completed this cycle
dhit  in  1  data access completed this cycle
dREN_EX_MEM  in  1  load in MEM stage
dWEN_EX_MEM  in  1  store in MEM stage
halt_EX_MEM  in  1  halt instruction in MEM stage
branch_taken_EX_MEM  in  1  resolved taken branch in MEM
jump_IF_ID  in  1  J/JAL/JR decoded in ID
dREN_ID_EX  in  1  load in EX
WEN_ID_EX  in  1  EX instruction writes regfile
Rt_ID_EX  in  5  load destination in EX
Rs_IF_ID, Rt_IF_ID  in  5 each  source regs in ID
pc_enable  out  1  PC update
enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each
flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  load bubble on next edge
dmem_req_ok  out  1  permit dREN/dWEN to cache (masks re-request)
halt  out  1  sticky processor halt
ctrl_state  out  2  RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3
stall_count  out  STALL_CNT_W  cycles with pc_enable=0 while not HALTED

Behaviour:
- Reset (async, RST=1): state RUN, halt=0, stall_count=0. All enables 0, all flushes 0, dmem_req_ok=1.
- Outputs are combinational from state and inputs. State, halt and stall_count are registered.
- mem_op = dREN_EX_MEM|dWEN_EX_MEM. mem_ok = !mem_op | dhit.
- load_use = dREN_ID_EX & WEN_ID_EX & (Rt_ID_EX!=0) & (Rt_ID_EX==Rs_IF_ID | Rt_ID_EX==Rt_IF_ID).
- RUN/MEM_WAIT priority, highest first:
  1. halt_EX_MEM & mem_ok: flush IF_ID, ID_EX, EX_MEM; enable all registers; pc_enable=0; next DRAIN.
  2. !mem_ok: every enable 0, pc_enable 0; next MEM_WAIT.
  3. mem_op & dhit & !ihit: enable EX_MEM and MEM_WB, flush_EX_MEM=1; freeze PC, IF_ID, ID_EX. The bubble keeps dhit from being lost. Next RUN.
  4. !ihit: all enables 0, pc_enable 0 (fetch wait); next RUN.
  5. branch_taken_EX_MEM: all enables 1, pc_enable 1, flush IF_ID, ID_EX, EX_MEM. Branch overrides load_use and jump.
  6. load_use: pc_enable 0, enable_IF_ID 0, flush_ID_EX 1, other enables 1.
  7. jump_IF_ID: all enables 1, flush_IF_ID 1.
  8. Otherwise all enables 1, pc_enable 1, no flush.
- MEM_WAIT returns to RUN on the cycle dhit is evaluated (same priority table).
- dmem_req_ok = 0 in the cycle after a dhit whose EX_MEM register did not advance. A registered flag, cleared when enable_EX_MEM=1. Otherwise dmem_req_ok=1.
- DRAIN (one cycle): enable_MEM_WB=1 only, everything else 0; set halt=1; next HALTED.
- HALTED: all enables 0, pc_enable 0, flushes 0, halt=1. Leaves only via RST.
- stall_count increments when pc_enable=0 and state!=HALTED. Saturates at all-ones.
- RST asserted mid-wait or mid-drain: immediate return to the reset values; no partial state survives.

Test Plan:
- Straight-line code, ihit=1 every cycle, no hazards -> all enables 1, no flushes, stall_count stays 0 after 10 cycles.
- Load in MEM, dhit low 3 cycles then high, ihit=1 -> state=1 for 3 cycles with all enables 0, then all enables 1 in the dhit cycle; stall_count=3.
- dhit=1 with ihit=0 -> enable_EX_MEM=1, flush_EX_MEM=1, enable_MEM_WB=1, pc_enable=0, enable_IF_ID=0, enable_ID_EX=0. The next cycle dmem_req_ok=1 because EX_MEM advanced.
- lw $5 in EX, add using $5 as Rs in ID -> pc_enable=0, enable_IF_ID=0, flush_ID_EX=1. The same case with Rt_ID_EX=0 -> no stall.
- branch_taken_EX_MEM=1 concurrent with load_use and jump_IF_ID -> flush IF_ID, ID_EX and EX_MEM all 1, pc_enable=1.
- halt_EX_MEM=1 -> DRAIN for 1 cycle (only enable_MEM_WB=1), then HALTED with halt=1 held for 20 cycles. RST pulse -> state=0, halt=0, stall_count=0.
